demux1x4_stream: RTL and testbench

DEMUX1X4_STREAM -- requirements
Module: demux1x4_stream

---
 rtl/demux1x4_stream.sv | 110 +++++++++++
 tb/tb_demux1x4_stream.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/demux1x4_stream.sv
// One-input, four-output stream demultiplexer with packet locking and
// per-channel completed-packet counters. Single holding register, no bubbles.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | between packets; next accepted beat routes by in_sel
// LOCKED | mid-packet; beats route to lock_sel, in_sel is ignored
module demux1x4_stream #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic             in_last,
    input  logic [1:0]       in_sel,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [31:0]      pkt_cnt,
    output logic             busy
);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t           state, state_nxt;
    logic [1:0]       lock_sel, lock_sel_nxt;
    logic [1:0]       dst;
    logic             hold_v;
    logic [1:0]       hold_dst;
    logic [WIDTH-1:0] hold_data;
    logic             hold_last;
    logic [7:0]       cnt [4];
    logic             accept;
    logic             drain;

    assign drain    = hold_v & out_ready[hold_dst];
    assign in_ready = ~hold_v | out_ready[hold_dst];
    assign accept   = in_valid & in_ready;
    assign out_data = hold_data;
    assign out_last = hold_last;
    assign busy     = (state == LOCKED);

    always_comb begin
        out_valid = '0;
        if (hold_v) out_valid[hold_dst] = 1'b1;
    end

    always_comb begin
        pkt_cnt = '0;
        for (int i = 0; i < 4; i++) pkt_cnt[8*i +: 8] = cnt[i];
    end

    always_comb begin
        state_nxt    = state;
        lock_sel_nxt = lock_sel;
        dst          = (state == LOCKED) ? lock_sel : in_sel;
        case (state)
            IDLE: begin
                if (accept && !in_last) begin
                    state_nxt    = LOCKED;
                    lock_sel_nxt = in_sel;
                end
            end
            LOCKED: begin
                if (accept && in_last) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            lock_sel <= 2'd0;
        end else begin
            state    <= state_nxt;
            lock_sel <= lock_sel_nxt;
        end
    end

    // Accept wins over drain so a drain+accept reloads with no bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_v    <= 1'b0;
            hold_dst  <= 2'd0;
            hold_data <= '0;
            hold_last <= 1'b0;
        end else if (accept) begin
            hold_v    <= 1'b1;
            hold_dst  <= dst;
            hold_data <= in_data;
            hold_last <= in_last;
        end else if (drain) begin
            hold_v    <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) cnt[i] <= 8'd0;
        end else if (drain && hold_last) begin
            for (int i = 0; i < 4; i++)
                if (hold_dst == 2'(i)) cnt[i] <= cnt[i] + 8'd1;
        end
    end

endmodule

// File: tb/tb_demux1x4_stream.sv
// Bench for demux1x4_stream: queue-based packet model checked every cycle,
// plus directed scenarios with literal expectations and a random regression.
module tb_demux1x4_stream;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [7:0]  in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic [1:0]  in_sel = '0;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_last;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready = 4'hF;
    logic [31:0] pkt_cnt;
    logic        busy;

    demux1x4_stream #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_sel(in_sel), .in_ready(in_ready),
        .out_data(out_data), .out_last(out_last), .out_valid(out_valid),
        .out_ready(out_ready), .pkt_cnt(pkt_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the block is a one-deep FIFO of beats, each tagged with the
    // channel its packet started on.
    typedef struct {
        logic [7:0] data;
        logic       last;
        logic [1:0] dst;
    } beat_t;

    beat_t      mq[$];
    bit         m_in_pkt = 1'b0;
    logic [1:0] m_dst = 2'd0;
    logic [7:0] m_cnt [4] = '{8'd0, 8'd0, 8'd0, 8'd0};
    bit         m_rdy;
    logic [1:0] m_d;
    int         n_drained = 0;

    always @(negedge rst_n) begin
        mq.delete();
        m_in_pkt = 1'b0;
        m_dst    = 2'd0;
        for (int i = 0; i < 4; i++) m_cnt[i] = 8'd0;
    end

    always @(posedge clk) begin
        if (rst_n) begin
            if (|(out_valid & out_ready)) n_drained++;
            m_rdy = (mq.size() == 0) || out_ready[mq[0].dst];
            if (mq.size() != 0 && out_ready[mq[0].dst]) begin
                if (mq[0].last) m_cnt[mq[0].dst] = m_cnt[mq[0].dst] + 8'd1;
                void'(mq.pop_front());
            end
            if (in_valid && m_rdy) begin
                m_d = m_in_pkt ? m_dst : in_sel;
                mq.push_back('{in_data, in_last, m_d});
                m_in_pkt = !in_last;
                m_dst    = m_d;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            if (mq.size() != 0) begin
                chk("m_out_valid", {28'd0, out_valid}, {28'd0, 4'b0001 << mq[0].dst});
                chk("m_out_data", {24'd0, out_data}, {24'd0, mq[0].data});
                chk("m_out_last", {31'd0, out_last}, {31'd0, mq[0].last});
                chk("m_in_ready", {31'd0, in_ready}, {31'd0, out_ready[mq[0].dst]});
            end else begin
                chk("m_out_valid", {28'd0, out_valid}, 32'd0);
                chk("m_in_ready", {31'd0, in_ready}, 32'd1);
            end
            chk("m_busy", {31'd0, busy}, {31'd0, m_in_pkt});
            chk("m_pkt_cnt", pkt_cnt, {m_cnt[3], m_cnt[2], m_cnt[1], m_cnt[0]});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        out_ready = 4'hF;
        rst_n     = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic drive(input logic [7:0] d, input logic l, input logic [1:0] s);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        in_sel   = s;
    endtask

    logic [3:0] ov_lit [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    int sent_pkts [4];
    int sent_beats, pk, cur_len, cur_idx;
    logic [1:0] cur_sel;
    bit acc;

    initial begin
        #1 rst_n = 1'b0;
        tick();
        chk("rst_out_valid", {28'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_pkt_cnt", pkt_cnt, 32'd0);
        chk("rst_out_data", {23'd0, out_last, out_data}, 32'd0);
        chk_en = 1'b1;
        do_reset();

        // Single-beat packets to every channel
        for (int i = 0; i < 4; i++) begin
            drive(8'hA5, 1'b1, 2'(i));
            tick();
            chk("single_ov", {28'd0, out_valid}, {28'd0, ov_lit[i]});
            chk("single_data", {24'd0, out_data}, 32'hA5);
        end
        in_valid = 1'b0;
        tick();
        chk("single_cnt", pkt_cnt, 32'h01010101);
        chk("single_busy", {31'd0, busy}, 32'd0);

        // Packet lock: in_sel changes after beat 0 are ignored
        do_reset();
        for (int b = 0; b < 4; b++) begin
            drive(8'h10 + 8'(b), (b == 3), (b == 0) ? 2'd2 : 2'd1);
            chk("lock_busy", {31'd0, busy}, {31'd0, (b != 0)});
            tick();
            chk("lock_ov", {28'd0, out_valid}, 32'h4);
            chk("lock_data", {24'd0, out_data}, 32'h10 + b);
        end
        in_valid = 1'b0;
        tick();
        chk("lock_busy_end", {31'd0, busy}, 32'd0);
        chk("lock_cnt2", {24'd0, pkt_cnt[23:16]}, 32'd1);
        chk("lock_cnt1", {24'd0, pkt_cnt[15:8]}, 32'd0);

        // Backpressure on channel 3, then drain+accept in one cycle
        do_reset();
        out_ready = 4'b0111;
        drive(8'h3C, 1'b1, 2'd3);
        tick();
        drive(8'h55, 1'b1, 2'd3);
        for (int k = 0; k < 5; k++) begin
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_data", {24'd0, out_data}, 32'h3C);
            chk("bp_ov", {28'd0, out_valid}, 32'h8);
            tick();
        end
        out_ready = 4'hF;
        #1;
        chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
        tick();
        chk("bp_next_data", {24'd0, out_data}, 32'h55);
        chk("bp_next_ov", {28'd0, out_valid}, 32'h8);
        chk("bp_cnt3_a", {24'd0, pkt_cnt[31:24]}, 32'd1);
        in_valid = 1'b0;
        tick();
        chk("bp_cnt3_b", {24'd0, pkt_cnt[31:24]}, 32'd2);

        // Counter wrap on channel 1
        do_reset();
        for (int i = 0; i < 256; i++) begin
            drive(8'(i), 1'b1, 2'd1);
            tick();
        end
        in_valid = 1'b0;
        tick();
        chk("wrap_cnt", pkt_cnt, 32'd0);

        // Reset in the middle of a 5-beat packet
        do_reset();
        drive(8'h70, 1'b0, 2'd0);
        tick();
        drive(8'h71, 1'b0, 2'd0);
        tick();
        drive(8'h72, 1'b0, 2'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_ov", {28'd0, out_valid}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_ready", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        drive(8'hE0, 1'b0, 2'd3);
        tick();
        chk("post_rst_ov0", {28'd0, out_valid}, 32'h8);
        drive(8'hE1, 1'b1, 2'd0);
        tick();
        chk("post_rst_ov1", {28'd0, out_valid}, 32'h8);
        in_valid = 1'b0;
        tick();
        chk("post_rst_cnt", pkt_cnt, 32'h01000000);

        // Random regression
        do_reset();
        for (int i = 0; i < 4; i++) sent_pkts[i] = 0;
        sent_beats = 0;
        pk = 0;
        cur_len = $urandom_range(1, 8);
        cur_sel = 2'($urandom_range(0, 3));
        cur_idx = 0;
        n_drained = 0;
        for (int cyc = 0; cyc < 4000 && pk < 60; cyc++) begin
            out_ready = 4'($urandom);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = 8'($urandom);
            in_last   = (cur_idx == cur_len - 1);
            in_sel    = (cur_idx == 0) ? cur_sel : 2'($urandom_range(0, 3));
            #1;
            acc = in_valid && in_ready;
            tick();
            if (acc) begin
                sent_beats++;
                cur_idx++;
                if (cur_idx == cur_len) begin
                    sent_pkts[cur_sel]++;
                    pk++;
                    cur_len = $urandom_range(1, 8);
                    cur_sel = 2'($urandom_range(0, 3));
                    cur_idx = 0;
                end
            end
        end
        chk("rand_budget", pk, 60);
        in_valid  = 1'b0;
        out_ready = 4'hF;
        tick();
        tick();
        tick();
        for (int i = 0; i < 4; i++)
            chk("rand_cnt", {24'd0, pkt_cnt[8*i +: 8]}, {24'd0, 8'(sent_pkts[i])});
        chk("rand_beats", n_drained, sent_beats);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
